// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives next PC, issues one-outstanding imem requests, owns IF/ID.
// Optional FETCH_PERF_EN adds fetch and bubble performance counters.
module fetch_ctrl #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [XLEN-1:0] PC_STEP   = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_id,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_t          state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    entry_t          buf_q, buf_d;
    entry_t          resp;
    entry_t          load_entry;
    logic            ifid_load;
    logic            slot_free;
    logic            ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_d;

    // Next-state, memory handshake, next PC and IF/ID update
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        req_pc_d     = req_pc_q;
        buf_d        = buf_q;
        imem_req     = 1'b0;
        imem_addr    = '0;
        next_pc      = pc_in;
        ifid_load    = 1'b0;
        load_entry   = buf_q;
        slot_free    = !if_id_valid || !stall_id;
        resp.pc      = req_pc_q;
        resp.instr   = imem_rdata;

        case (state_q)
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                if (imem_gnt) begin
                    req_pc_d = pc_in;
                    next_pc  = pc_in + PC_STEP;
                    state_d  = S_WAIT;
                    // a redirect in the grant cycle makes this request stale
                    kill_d   = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect_valid) begin
                        if (slot_free) begin
                            ifid_load  = 1'b1;
                            load_entry = resp;
                        end else begin
                            buf_d   = resp;
                            state_d = S_HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (!stall_id) begin
                    ifid_load  = 1'b1;
                    load_entry = buf_q;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                kill_d  = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            next_pc = redirect_pc;
        end

        ifid_valid_d = if_id_valid;
        ifid_pc_d    = if_id_pc;
        ifid_instr_d = if_id_instr;
        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (ifid_load) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = load_entry.pc;
            ifid_instr_d = load_entry.instr;
        end else if (!stall_id) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            kill_q      <= 1'b0;
            req_pc_q    <= '0;
            buf_q       <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            req_pc_q    <= req_pc_d;
            buf_q       <= buf_d;
            if_id_valid <= ifid_valid_d;
            if_id_pc    <= ifid_pc_d;
            if_id_instr <= ifid_instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    // Loads into IF/ID, and cycles where ID is left without an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            perf_fetch_cnt  <= perf_fetch_cnt + XLEN'(ifid_load);
            perf_bubble_cnt <= perf_bubble_cnt + XLEN'(!stall_id && !ifid_valid_d);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run against a queue-level model.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall_id = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_id(stall_id),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding fetch, one parked response, the IF/ID slot
    bit          m_out = 0, m_kill = 0, m_hb = 0, m_qv = 0;
    logic [31:0] m_out_pc = 0, m_hb_pc = 0, m_hb_instr = 0, m_q_pc = 0, m_q_instr = NOP;
    logic [31:0] m_fcnt = 0, m_bcnt = 0;
    bit          n_out, n_kill, n_hb, n_qv;
    logic [31:0] n_out_pc, n_hb_pc, n_hb_instr, n_q_pc, n_q_instr, n_fcnt, n_bcnt;
    logic        e_req;
    logic [31:0] e_addr, e_next;

    function automatic void model_eval();
        bit          ld;
        logic [31:0] ld_pc, ld_instr;
        e_req  = !m_out && !m_hb;
        e_addr = e_req ? pc_in : 32'h0;
        if (redirect_valid)          e_next = redirect_pc;
        else if (e_req && imem_gnt)  e_next = pc_in + 32'd4;
        else                         e_next = pc_in;
        n_out = m_out; n_kill = m_kill; n_hb = m_hb; n_qv = m_qv;
        n_out_pc = m_out_pc; n_hb_pc = m_hb_pc; n_hb_instr = m_hb_instr;
        n_q_pc = m_q_pc; n_q_instr = m_q_instr; n_fcnt = m_fcnt; n_bcnt = m_bcnt;
        ld = 0; ld_pc = 0; ld_instr = 0;
        if (reset) begin
            n_out = 0; n_kill = 0; n_hb = 0; n_qv = 0;
            n_q_pc = 0; n_q_instr = NOP; n_fcnt = 0; n_bcnt = 0;
            return;
        end
        if (e_req && imem_gnt) begin
            n_out = 1; n_kill = redirect_valid; n_out_pc = pc_in;
        end else if (m_out && imem_rvalid) begin
            n_out = 0; n_kill = 0;
            if (!m_kill && !redirect_valid) begin
                if (!m_qv || !stall_id) begin
                    ld = 1; ld_pc = m_out_pc; ld_instr = imem_rdata;
                end else begin
                    n_hb = 1; n_hb_pc = m_out_pc; n_hb_instr = imem_rdata;
                end
            end
        end else if (m_out && redirect_valid) begin
            n_kill = 1;
        end else if (m_hb && (redirect_valid || !stall_id)) begin
            n_hb = 0;
            if (!redirect_valid) begin
                ld = 1; ld_pc = m_hb_pc; ld_instr = m_hb_instr;
            end
        end
        if (redirect_valid) begin
            n_qv = 0; n_q_instr = NOP;
        end else if (ld) begin
            n_qv = 1; n_q_pc = ld_pc; n_q_instr = ld_instr;
        end else if (!stall_id) begin
            n_qv = 0; n_q_instr = NOP;
        end
        if (ld) n_fcnt = m_fcnt + 32'd1;
        if (!stall_id && !n_qv) n_bcnt = m_bcnt + 32'd1;
    endfunction

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdr, input logic [31:0] rpc, input logic st, input logic rst);
        @(negedge clk);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdr; redirect_pc = rpc; stall_id = st; reset = rst;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_out = n_out; m_kill = n_kill; m_hb = n_hb; m_qv = n_qv;
        m_out_pc = n_out_pc; m_hb_pc = n_hb_pc; m_hb_instr = n_hb_instr;
        m_q_pc = n_q_pc; m_q_instr = n_q_instr; m_fcnt = n_fcnt; m_bcnt = n_bcnt;
        pc_in = e_next;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", if_id_valid); end
        n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0", if_id_pc); end
        n_tests++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h want=%h", if_id_instr, NOP); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got=%0b want=1", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        tick();
    endtask

    task automatic test_basic_fetch();
        pc_in = 32'h0;
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (next_pc !== 32'h4) begin n_fail++; $display("FAIL basic_next got=%h want=4", next_pc); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr got=%h want=0", imem_addr); end
        tick();
        drive(0, 1, 32'h0050_0093, 0, 0, 0, 0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req got=%0b want=0", imem_req); end
        n_tests++; if (next_pc !== 32'h4) begin n_fail++; $display("FAIL basic_wait_next got=%h want=4", next_pc); end
        tick();
        n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b want=1", if_id_valid); end
        n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL basic_pc got=%h want=0", if_id_pc); end
        n_tests++; if (if_id_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr got=%h want=00500093", if_id_instr); end
    endtask

    task automatic test_gnt_wait();
        pc_in = 32'h10;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_tests++; if (imem_req !== 1'b1 || next_pc !== 32'h10) begin
                n_fail++; $display("FAIL nognt_cycle%0d req=%0b next=%h want req=1 next=10", i, imem_req, next_pc);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (next_pc !== 32'h14) begin n_fail++; $display("FAIL nognt_grant_next got=%h want=14", next_pc); end
        tick();
        drive(0, 1, 32'h0000_1111, 0, 0, 0, 0); tick();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10) begin
            n_fail++; $display("FAIL nognt_load valid=%0b pc=%h want 1/10", if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_stall_hold();
        pc_in = 32'h4;
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h0010_0093, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 1, 32'h00A0_0113, 0, 0, 1, 0); tick();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_instr !== 32'h0010_0093) begin
            n_fail++; $display("FAIL hold_keep got=%0b/%h/%h want 1/4/00100093", if_id_valid, if_id_pc, if_id_instr);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got=%0b want=0", imem_req); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'h00A0_0113) begin
            n_fail++; $display("FAIL hold_release got=%0b/%h/%h want 1/8/00a00113", if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_redirect_wait();
        pc_in = 32'h40;
        drive(1, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 32'h100, 1, 0);
        n_tests++; if (next_pc !== 32'h100) begin n_fail++; $display("FAIL rdw_next got=%h want=100", next_pc); end
        tick();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            n_fail++; $display("FAIL rdw_flush got=%0b/%h want 0/%h", if_id_valid, if_id_instr, NOP);
        end
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0); tick();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_drop got=%0b want=0", if_id_valid); end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL rdw_refetch req=%0b addr=%h want 1/100", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect_gnt();
        pc_in = 32'h20;
        drive(1, 0, 0, 1, 32'h200, 0, 0);
        n_tests++; if (next_pc !== 32'h200 || imem_addr !== 32'h20) begin
            n_fail++; $display("FAIL rdg_issue next=%h addr=%h want 200/20", next_pc, imem_addr);
        end
        tick();
        drive(0, 1, 32'h1234_5678, 0, 0, 0, 0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdg_wait_req got=%0b want=0", imem_req); end
        tick();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rdg_discard got=%0b want=0", if_id_valid); end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdg_target got=%h want=200", imem_addr); end
        tick();
        drive(0, 1, 32'h0000_0093, 0, 0, 0, 0); tick();
        n_tests++; if (if_id_pc !== 32'h200 || if_id_instr !== 32'h0000_0093) begin
            n_fail++; $display("FAIL rdg_load got=%h/%h want 200/00000093", if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        pc_in = 32'hFFFF_FFFC;
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++; if (next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%h want=0", next_pc); end
        tick();
        drive(0, 1, 32'h0000_2222, 0, 0, 0, 0); tick();
        n_tests++; if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h want=fffffffc", if_id_pc); end
    endtask

    task automatic test_reset_mid();
        pc_in = 32'h80;
        drive(1, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 32'h300, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 1); tick();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== NOP) begin
            n_fail++; $display("FAIL midreset_ifid got=%0b/%h/%h want 0/0/%h", if_id_valid, if_id_pc, if_id_instr, NOP);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== pc_in) begin
            n_fail++; $display("FAIL midreset_req req=%0b addr=%h want 1/%h", imem_req, imem_addr, pc_in);
        end
        tick();
    endtask

    task automatic test_random();
        int cd = 0;
        bit granted;
        logic g, rv, rdr, st, rst;
        for (int i = 0; i < 3000; i++) begin
            g   = ($urandom_range(0, 1) == 1);
            st  = ($urandom_range(0, 9) < 3);
            rdr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            rv  = m_out ? (cd == 0) : ($urandom_range(0, 19) == 0);
            drive(g, rv, $urandom, rdr, {$urandom_range(0, 32'h3FFF), 2'b00}, st, rst);
            n_tests++; if (imem_req !== e_req || imem_addr !== e_addr || next_pc !== e_next) begin
                n_fail++; $display("FAIL rnd_comb cyc%0d req=%0b addr=%h next=%h want %0b/%h/%h",
                                   i, imem_req, imem_addr, next_pc, e_req, e_addr, e_next);
            end
            granted = e_req && g && !rst;
            tick();
            if (granted) cd = $urandom_range(0, 3);
            else if (m_out && cd > 0) cd--;
            n_tests++; if (if_id_valid !== m_qv || if_id_instr !== m_q_instr || (m_qv && if_id_pc !== m_q_pc)) begin
                n_fail++; $display("FAIL rnd_ifid cyc%0d got=%0b/%h/%h want %0b/%h/%h",
                                   i, if_id_valid, if_id_pc, if_id_instr, m_qv, m_q_pc, m_q_instr);
            end
`ifdef FETCH_PERF_EN
            n_tests++; if (perf_fetch_cnt !== m_fcnt || perf_bubble_cnt !== m_bcnt) begin
                n_fail++; $display("FAIL rnd_perf cyc%0d got=%0d/%0d want %0d/%0d",
                                   i, perf_fetch_cnt, perf_bubble_cnt, m_fcnt, m_bcnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_gnt_wait();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
